// File: rtl/ariane_axi_pkg.sv
// ariane_axi: AXI4 channel and request/response bundle types used on the
// cache subsystem's merged master port. req_t travels master->slave
// (aw/w/ar payload + valids, b/r readys); resp_t travels slave->master.
package ariane_axi;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared definitions for the AXI transaction limiter.
// Holds the limiter state encoding and its default limits; the outstanding
// write limit matches the cache subsystem's 4-entry W FIFO.
package ariane_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HUNG = 2'd2
  } limiter_state_e;

  localparam int unsigned LIMITER_MAX_RD         = 4;
  localparam int unsigned LIMITER_MAX_WR         = 4;
  localparam int unsigned LIMITER_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_txn_limiter_txn_counter.sv
// txn_counter: saturating up/down counter, range 0..MAX.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i, dec_i : count events; both in one cycle leave the count unchanged
//   count_o      : current count
//   at_max_o     : count_o == MAX
// A decrement at zero holds zero and trips the underflow assertion.
module txn_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   count_o,
  output logic                       at_max_o
);

  localparam int unsigned CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != MAX_C)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = (count_q == MAX_C);

  underflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/axi_txn_limiter.sv
// axi_txn_limiter: sits between the cache subsystem's merged AXI master port
// and the interconnect. Caps outstanding reads/writes, holds W until its AW
// has been accepted, and flags a hung interconnect with a watchdog.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   slv_req_i/resp_o   : upstream (cache subsystem) side
//   mst_req_o/resp_i   : downstream (interconnect) side
//   rd_outstanding_o   : AR accepted, R last not yet seen
//   wr_outstanding_o   : AW accepted, B not yet seen
//   timeout_o          : sticky, set on entry to HUNG, cleared by reset
//   idle_o             : both counts are zero
// Handshake rule: a transfer happens on a channel in a cycle where its valid
// and ready are both high. Gates only AND valid/ready with a signal derived
// from registered state (plus rst_i), so no valid<->ready path is created and
// payload passes through with zero latency.
module axi_txn_limiter
  import ariane_pkg::*;
#(
  parameter int unsigned MAX_RD         = LIMITER_MAX_RD,
  parameter int unsigned MAX_WR         = LIMITER_MAX_WR,
  parameter int unsigned TIMEOUT_CYCLES = LIMITER_TIMEOUT_CYCLES,
  localparam int unsigned RD_CW = $clog2(MAX_RD + 1),
  localparam int unsigned WR_CW = $clog2(MAX_WR + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  ariane_axi::req_t   slv_req_i,
  output ariane_axi::resp_t  slv_resp_o,
  output ariane_axi::req_t   mst_req_o,
  input  ariane_axi::resp_t  mst_resp_i,
  output logic [RD_CW-1:0]   rd_outstanding_o,
  output logic [WR_CW-1:0]   wr_outstanding_o,
  output logic               timeout_o,
  output logic               idle_o
);

  // With the watchdog disabled keep a 1-bit counter pinned at zero.
  localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  logic [RD_CW-1:0] rd_cnt;
  logic [WR_CW-1:0] wr_cnt, w_pend;
  logic             rd_full, wr_full, w_pend_full;
  logic             ar_gate, aw_gate, w_gate;
  logic             ar_hs, aw_hs, w_last_hs, r_hs, r_last_hs, b_hs;
  logic             rd_zero_next, wr_zero_next;

  limiter_state_e   state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;

  assign ar_gate = !rst_i && (state_q != HUNG) && !rd_full;
  assign aw_gate = !rst_i && (state_q != HUNG) && !wr_full;
  // w_pend is registered, so W stays closed in the cycle of its own AW.
  assign w_gate  = !rst_i && (w_pend != '0);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_gate;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_gate;
    mst_req_o.w_valid  = slv_req_i.w_valid  & w_gate;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_gate;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_gate;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & w_gate;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign w_last_hs = mst_req_o.w_valid & mst_resp_i.w_ready & slv_req_i.w.last;
  assign r_hs      = mst_resp_i.r_valid & slv_req_i.r_ready;
  assign r_last_hs = r_hs & mst_resp_i.r.last;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

  txn_counter #(.MAX(MAX_RD)) u_rd_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(ar_hs), .dec_i(r_last_hs),
    .count_o(rd_cnt), .at_max_o(rd_full)
  );

  txn_counter #(.MAX(MAX_WR)) u_wr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs), .dec_i(b_hs),
    .count_o(wr_cnt), .at_max_o(wr_full)
  );

  // Bursts whose AW is accepted but whose W last has not yet gone out.
  // Never exceeds wr_cnt, so MAX_WR is a safe ceiling.
  txn_counter #(.MAX(MAX_WR)) u_w_pend (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs), .dec_i(w_last_hs),
    .count_o(w_pend), .at_max_o(w_pend_full)
  );

  // Count value after the coming edge is zero.
  assign rd_zero_next = ((rd_cnt == '0) && !(ar_hs && !r_last_hs)) ||
                        ((rd_cnt == RD_CW'(1)) && r_last_hs && !ar_hs);
  assign wr_zero_next = ((wr_cnt == '0) && !(aw_hs && !b_hs)) ||
                        ((wr_cnt == WR_CW'(1)) && b_hs && !aw_hs);

  always_comb begin
    wd_d = wd_q;
    if (r_hs || b_hs || ((rd_cnt == '0) && (wr_cnt == '0))) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!(rd_zero_next && wr_zero_next)) state_d = BUSY;
      BUSY: begin
        if (rd_zero_next && wr_zero_next) begin
          state_d = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_d == WD_MAX)) begin
          state_d = HUNG;
        end
      end
      HUNG: if (rd_zero_next && wr_zero_next) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    timeout_d = timeout_q | ((state_d == HUNG) && (state_q != HUNG));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign rd_outstanding_o = rd_cnt;
  assign wr_outstanding_o = wr_cnt;
  assign timeout_o        = timeout_q;
  assign idle_o           = (rd_cnt == '0) && (wr_cnt == '0);

  w_pend_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    !(aw_hs && w_pend_full && !w_last_hs));

endmodule

// File: tb/tb_axi_txn_limiter.sv
module tb_axi_txn_limiter;
  import ariane_axi::*;

  localparam int A_MAX_RD = 4;
  localparam int A_MAX_WR = 4;
  localparam int A_TO     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_t  a_slv_req, a_mst_req, b_slv_req, b_mst_req;
  resp_t a_slv_resp, a_mst_resp, b_slv_resp, b_mst_resp;
  logic [2:0] a_rd_out, a_wr_out;
  logic       a_to, a_idle;
  logic [1:0] b_rd_out, b_wr_out;
  logic       b_to, b_idle;

  axi_txn_limiter #(.MAX_RD(A_MAX_RD), .MAX_WR(A_MAX_WR), .TIMEOUT_CYCLES(A_TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(a_slv_req), .slv_resp_o(a_slv_resp),
    .mst_req_o(a_mst_req), .mst_resp_i(a_mst_resp),
    .rd_outstanding_o(a_rd_out), .wr_outstanding_o(a_wr_out),
    .timeout_o(a_to), .idle_o(a_idle)
  );

  axi_txn_limiter #(.MAX_RD(2), .MAX_WR(2), .TIMEOUT_CYCLES(0)) dut_nowd (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(b_slv_req), .slv_resp_o(b_slv_resp),
    .mst_req_o(b_mst_req), .mst_resp_i(b_mst_resp),
    .rd_outstanding_o(b_rd_out), .wr_outstanding_o(b_wr_out),
    .timeout_o(b_to), .idle_o(b_idle)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of dut: plain counts of open transactions.
  int m_rd = 0, m_wr = 0, m_wp = 0, m_wd = 0;
  bit m_hung = 0, m_to = 0;

  function automatic bit ar_open();
    return !rst && !m_hung && (m_rd < A_MAX_RD);
  endfunction
  function automatic bit aw_open();
    return !rst && !m_hung && (m_wr < A_MAX_WR);
  endfunction
  function automatic bit w_open();
    return !rst && (m_wp > 0);
  endfunction

  task automatic clear_a();
    a_slv_req  = '0;
    a_mst_resp = '0;
  endtask

  // Advance one clock and move the model by the handshakes of this cycle.
  task automatic cycle();
    bit arh, awh, wlh, rh, rlh, bh, r0;
    int nwd;
    r0  = rst;
    arh = a_slv_req.ar_valid && a_mst_resp.ar_ready && ar_open();
    awh = a_slv_req.aw_valid && a_mst_resp.aw_ready && aw_open();
    wlh = a_slv_req.w_valid && a_mst_resp.w_ready && w_open() && a_slv_req.w.last;
    rh  = a_mst_resp.r_valid && a_slv_req.r_ready;
    rlh = rh && a_mst_resp.r.last;
    bh  = a_mst_resp.b_valid && a_slv_req.b_ready;
    @(posedge clk);
    if (r0) begin
      m_rd = 0; m_wr = 0; m_wp = 0; m_wd = 0; m_hung = 0; m_to = 0;
    end else begin
      if (rh || bh || (m_rd + m_wr == 0)) nwd = 0;
      else nwd = (m_wd < A_TO) ? m_wd + 1 : A_TO;
      m_rd = m_rd + int'(arh) - int'(rlh); if (m_rd < 0) m_rd = 0;
      m_wr = m_wr + int'(awh) - int'(bh);  if (m_wr < 0) m_wr = 0;
      m_wp = m_wp + int'(awh) - int'(wlh); if (m_wp < 0) m_wp = 0;
      m_wd = nwd;
      if (m_rd == 0 && m_wr == 0) m_hung = 0;
      else if (nwd == A_TO) begin m_hung = 1; m_to = 1; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_a();
    a_slv_req.ar_valid = 1'b1; a_slv_req.aw_valid = 1'b1;
    a_mst_resp.ar_ready = 1'b1; a_mst_resp.aw_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (a_mst_req.ar_valid !== 1'b0 || a_mst_req.aw_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_valid: got ar=%0b aw=%0b want 0 0", a_mst_req.ar_valid, a_mst_req.aw_valid);
      end
      n_cmp++;
      if (a_slv_resp.ar_ready !== 1'b0 || a_slv_resp.aw_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_ready: got ar=%0b aw=%0b want 0 0", a_slv_resp.ar_ready, a_slv_resp.aw_ready);
      end
      cycle();
      n_cmp++;
      if ({a_rd_out, a_wr_out, a_to, a_idle} !== 8'b000_000_0_1) begin
        n_err++; $display("FAIL reset_outputs: got rd=%0d wr=%0d to=%0b idle=%0b want 0 0 0 1", a_rd_out, a_wr_out, a_to, a_idle);
      end
    end
    n_cmp++;
    if ({b_rd_out, b_wr_out, b_to, b_idle} !== 6'b00_00_0_1) begin
      n_err++; $display("FAIL reset_outputs_nowd: got rd=%0d wr=%0d to=%0b idle=%0b want 0 0 0 1", b_rd_out, b_wr_out, b_to, b_idle);
    end
    rst = 1'b0;
    clear_a();
  endtask

  task automatic test_wd_disabled();
    bit any_to = 0;
    b_slv_req.ar_valid = 1'b1; b_mst_resp.ar_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_slv_req.ar_valid = 1'b0; b_mst_resp.ar_ready = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (b_to !== 1'b0) any_to = 1;
    end
    n_cmp++;
    if (any_to || b_to !== 1'b0) begin
      n_err++; $display("FAIL nowd_timeout: got to=%0b seen=%0b want 0 0", b_to, any_to);
    end
    n_cmp++;
    if (b_rd_out !== 2'd1 || b_idle !== 1'b0) begin
      n_err++; $display("FAIL nowd_count: got rd=%0d idle=%0b want 1 0", b_rd_out, b_idle);
    end
    b_slv_req.ar_valid = 1'b1;
    #1;
    n_cmp++;
    if (b_mst_req.ar_valid !== 1'b1) begin
      n_err++; $display("FAIL nowd_gate_open: got %0b want 1", b_mst_req.ar_valid);
    end
    b_slv_req.ar_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_limit();
    a_slv_req.ar_valid = 1'b1; a_mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_slv_req.ar.id = 4'(i);
      #1;
      n_cmp++;
      if (a_mst_req.ar_valid !== (i < 4)) begin
        n_err++; $display("FAIL rd_limit_ar%0d: got %0b want %0b", i, a_mst_req.ar_valid, (i < 4));
      end
      cycle();
    end
    n_cmp++;
    if (a_rd_out !== 3'd4 || a_slv_resp.ar_ready !== 1'b0) begin
      n_err++; $display("FAIL rd_limit_full: got rd=%0d ready=%0b want 4 0", a_rd_out, a_slv_resp.ar_ready);
    end
    a_mst_resp.r_valid = 1'b1; a_mst_resp.r.last = 1'b1; a_slv_req.r_ready = 1'b1;
    cycle();
    a_mst_resp.r_valid = 1'b0;
    #1;
    n_cmp++;
    if (a_slv_resp.ar_ready !== 1'b1 || a_mst_req.ar_valid !== 1'b1) begin
      n_err++; $display("FAIL rd_limit_reopen: got ready=%0b valid=%0b want 1 1", a_slv_resp.ar_ready, a_mst_req.ar_valid);
    end
    cycle();
    a_slv_req.ar_valid = 1'b0;
    n_cmp++;
    if (a_rd_out !== 3'd4) begin
      n_err++; $display("FAIL rd_limit_fifth: got %0d want 4", a_rd_out);
    end
    a_mst_resp.r_valid = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    clear_a();
    n_cmp++;
    if (a_rd_out !== 3'd0 || a_idle !== 1'b1 || a_to !== 1'b0) begin
      n_err++; $display("FAIL rd_limit_drain: got rd=%0d idle=%0b to=%0b want 0 1 0", a_rd_out, a_idle, a_to);
    end
  endtask

  task automatic test_same_cycle();
    a_slv_req.ar_valid = 1'b1; a_mst_resp.ar_ready = 1'b1;
    cycle(); cycle();
    a_mst_resp.r_valid = 1'b1; a_mst_resp.r.last = 1'b1; a_slv_req.r_ready = 1'b1;
    cycle();
    n_cmp++;
    if (a_rd_out !== 3'd2) begin
      n_err++; $display("FAIL same_cycle: got %0d want 2", a_rd_out);
    end
    a_slv_req.ar_valid = 1'b0;
    cycle(); cycle();
    clear_a();
    n_cmp++;
    if (a_rd_out !== 3'd0 || a_idle !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_drain: got rd=%0d idle=%0b want 0 1", a_rd_out, a_idle);
    end
  endtask

  task automatic test_w_order();
    a_slv_req.w_valid = 1'b1; a_slv_req.w.last = 1'b0; a_mst_resp.w_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (a_mst_req.w_valid !== 1'b0 || a_slv_resp.w_ready !== 1'b0) begin
        n_err++; $display("FAIL w_early%0d: got valid=%0b ready=%0b want 0 0", i, a_mst_req.w_valid, a_slv_resp.w_ready);
      end
      cycle();
    end
    a_slv_req.aw_valid = 1'b1; a_mst_resp.aw_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_mst_req.aw_valid !== 1'b1 || a_mst_req.w_valid !== 1'b0) begin
      n_err++; $display("FAIL w_same_as_aw: got aw=%0b w=%0b want 1 0", a_mst_req.aw_valid, a_mst_req.w_valid);
    end
    cycle();
    a_slv_req.aw_valid = 1'b0;
    for (int beat = 0; beat < 4; beat++) begin
      a_slv_req.w.last = (beat == 3);
      a_slv_req.w.data = {$urandom, $urandom};
      #1;
      n_cmp++;
      if (a_mst_req.w_valid !== 1'b1 || a_slv_resp.w_ready !== 1'b1 || a_mst_req.w.data !== a_slv_req.w.data) begin
        n_err++; $display("FAIL w_beat%0d: got valid=%0b ready=%0b data=%h want 1 1 %h", beat, a_mst_req.w_valid, a_slv_resp.w_ready, a_mst_req.w.data, a_slv_req.w.data);
      end
      cycle();
    end
    a_slv_req.w.last = 1'b0;
    #1;
    n_cmp++;
    if (a_mst_req.w_valid !== 1'b0 || a_wr_out !== 3'd1) begin
      n_err++; $display("FAIL w_pend_zero: got w=%0b wr=%0d want 0 1", a_mst_req.w_valid, a_wr_out);
    end
    a_slv_req.w_valid = 1'b0;
    a_mst_resp.b_valid = 1'b1; a_slv_req.b_ready = 1'b1;
    cycle();
    clear_a();
    n_cmp++;
    if (a_wr_out !== 3'd0 || a_idle !== 1'b1) begin
      n_err++; $display("FAIL w_b_done: got wr=%0d idle=%0b want 0 1", a_wr_out, a_idle);
    end
  endtask

  task automatic test_watchdog();
    a_slv_req.ar_valid = 1'b1; a_mst_resp.ar_ready = 1'b1;
    cycle();
    a_slv_req.ar_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      n_cmp++;
      if (a_to !== (i == 16)) begin
        n_err++; $display("FAIL wd_cycle%0d: got %0b want %0b", i, a_to, (i == 16));
      end
    end
    a_slv_req.aw_valid = 1'b1; a_mst_resp.aw_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_mst_req.aw_valid !== 1'b0 || a_slv_resp.aw_ready !== 1'b0) begin
      n_err++; $display("FAIL wd_aw_blocked: got valid=%0b ready=%0b want 0 0", a_mst_req.aw_valid, a_slv_resp.aw_ready);
    end
    cycle();
    a_slv_req.aw_valid = 1'b0;
    n_cmp++;
    if (a_wr_out !== 3'd0) begin
      n_err++; $display("FAIL wd_aw_count: got %0d want 0", a_wr_out);
    end
    a_mst_resp.r_valid = 1'b1; a_mst_resp.r.last = 1'b1; a_slv_req.r_ready = 1'b1;
    cycle();
    clear_a();
    n_cmp++;
    if (a_idle !== 1'b1 || a_to !== 1'b1) begin
      n_err++; $display("FAIL wd_late_r: got idle=%0b to=%0b want 1 1", a_idle, a_to);
    end
    a_slv_req.aw_valid = 1'b1;
    #1;
    n_cmp++;
    if (a_mst_req.aw_valid !== 1'b1) begin
      n_err++; $display("FAIL wd_reopen: got %0b want 1", a_mst_req.aw_valid);
    end
    clear_a();
  endtask

  task automatic test_random();
    bit quiet;
    logic [2:0] exp_v, got_v, exp_r, got_r;
    for (int i = 0; i < 600; i++) begin
      quiet = ((i % 150) >= 110);
      rst = ($urandom_range(0, 199) == 0);
      a_slv_req.ar = {$urandom, $urandom, $urandom};
      a_slv_req.aw = {$urandom, $urandom, $urandom};
      a_slv_req.w.data = {$urandom, $urandom};
      a_slv_req.w.strb = 8'($urandom);
      a_slv_req.w.last = ($urandom_range(0, 3) == 0);
      a_slv_req.ar_valid = 1'($urandom_range(0, 1));
      a_slv_req.aw_valid = 1'($urandom_range(0, 1));
      a_slv_req.w_valid  = 1'($urandom_range(0, 1));
      a_slv_req.r_ready  = 1'($urandom_range(0, 1));
      a_slv_req.b_ready  = 1'($urandom_range(0, 1));
      a_mst_resp.ar_ready = 1'($urandom_range(0, 1));
      a_mst_resp.aw_ready = 1'($urandom_range(0, 1));
      a_mst_resp.w_ready  = 1'($urandom_range(0, 1));
      a_mst_resp.r = {$urandom, $urandom, $urandom};
      a_mst_resp.b = 6'($urandom);
      a_mst_resp.r_valid = !quiet && (m_rd > 0) && ($urandom_range(0, 1) == 1);
      a_mst_resp.b_valid = !quiet && (m_wr > m_wp) && ($urandom_range(0, 1) == 1);
      #1;
      exp_v = {a_slv_req.ar_valid && ar_open(), a_slv_req.aw_valid && aw_open(), a_slv_req.w_valid && w_open()};
      got_v = {a_mst_req.ar_valid, a_mst_req.aw_valid, a_mst_req.w_valid};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++; $display("FAIL rand_valids@%0d: got %b want %b", i, got_v, exp_v);
      end
      exp_r = {a_mst_resp.ar_ready && ar_open(), a_mst_resp.aw_ready && aw_open(), a_mst_resp.w_ready && w_open()};
      got_r = {a_slv_resp.ar_ready, a_slv_resp.aw_ready, a_slv_resp.w_ready};
      n_cmp++;
      if (got_r !== exp_r) begin
        n_err++; $display("FAIL rand_readys@%0d: got %b want %b", i, got_r, exp_r);
      end
      n_cmp++;
      if ({a_mst_req.ar, a_mst_req.aw, a_mst_req.w, a_mst_req.r_ready, a_mst_req.b_ready} !==
          {a_slv_req.ar, a_slv_req.aw, a_slv_req.w, a_slv_req.r_ready, a_slv_req.b_ready}) begin
        n_err++; $display("FAIL rand_req_payload@%0d: got %h want %h", i, {a_mst_req.ar, a_mst_req.w}, {a_slv_req.ar, a_slv_req.w});
      end
      n_cmp++;
      if ({a_slv_resp.r_valid, a_slv_resp.r, a_slv_resp.b_valid, a_slv_resp.b} !==
          {a_mst_resp.r_valid, a_mst_resp.r, a_mst_resp.b_valid, a_mst_resp.b}) begin
        n_err++; $display("FAIL rand_resp_payload@%0d: got %h want %h", i, a_slv_resp.r, a_mst_resp.r);
      end
      cycle();
      n_cmp++;
      if (a_rd_out !== 3'(m_rd) || a_wr_out !== 3'(m_wr)) begin
        n_err++; $display("FAIL rand_counts@%0d: got rd=%0d wr=%0d want %0d %0d", i, a_rd_out, a_wr_out, m_rd, m_wr);
      end
      n_cmp++;
      if (a_to !== m_to || a_idle !== (m_rd == 0 && m_wr == 0)) begin
        n_err++; $display("FAIL rand_flags@%0d: got to=%0b idle=%0b want %0b %0b", i, a_to, a_idle, m_to, (m_rd == 0 && m_wr == 0));
      end
    end
    rst = 1'b0;
    clear_a();
  endtask

  initial begin
    clear_a();
    b_slv_req  = '0;
    b_mst_resp = '0;
    test_reset();
    test_wd_disabled();
    test_read_limit();
    test_same_cycle();
    test_w_order();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
